// File: rtl/eth_mac_pkg.sv
// Shared constants and types for the Ethernet MAC receive/transmit datapaths.
package eth_mac_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef logic [DATA_WIDTH-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } rx_state_t;

    // One outgoing AXI-stream beat (valid carried separately).
    typedef struct packed {
        byte_t tdata;
        logic  tlast;
        logic  tuser;
    } rx_beat_t;

endpackage

// File: rtl/eth_mac_rx_framer_if.sv
// Byte-in / AXI-stream-out signal bundle of the RX framer.
interface eth_mac_rx_framer_if;

    eth_mac_pkg::byte_t s_rx_data;
    logic               s_rx_dv;
    logic               s_rx_er;

    eth_mac_pkg::byte_t m_rx_axis_tdata;
    logic               m_rx_axis_tvalid;
    logic               m_rx_axis_tlast;
    logic               m_rx_axis_tuser;
    logic               o_crc_err;
    logic               o_frame_ok;

    // PHY-side source: drives bytes, observes the framed stream.
    modport master (
        output s_rx_data, s_rx_dv, s_rx_er,
        input  m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser,
        input  o_crc_err, o_frame_ok
    );

    // Framer side.
    modport slave (
        input  s_rx_data, s_rx_dv, s_rx_er,
        output m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser,
        output o_crc_err, o_frame_ok
    );

endinterface

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected CRC-32 register for one input byte (LSB first).
module crc32_d8
    import eth_mac_pkg::*;
(
    input  logic [31:0] crc_i,
    input  byte_t       data_i,
    output logic [31:0] crc_c_o
);

    logic [31:0] crc_w;

    always_comb begin
        crc_w = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_w[0] ^ data_i[i]) begin
                crc_w = (crc_w >> 1) ^ CRC32_POLY;
            end else begin
                crc_w = crc_w >> 1;
            end
        end
        crc_c_o = crc_w;
    end

endmodule

// File: rtl/eth_mac_rx_framer.sv
// RX framing stage: strips preamble/SFD and FCS, checks CRC-32, flags bad frames on tlast.
module eth_mac_rx_framer
    import eth_mac_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic clk_125,
    input  logic reset_n,
    eth_mac_rx_framer_if.slave rx_if
);

    localparam int unsigned CNT_W = $clog2(MAX_FRAME + 2);

    rx_state_t         state_q, state_d;
    logic [31:0]       crc_q, crc_d, crc_upd;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    byte_t [3:0]       dl_q, dl_d;
    byte_t             hold_q, hold_d;
    logic              err_q, err_d;
    rx_beat_t          beat_q, beat_d;
    logic              tvalid_q, tvalid_d;
    logic              crc_err_q, crc_err_d;
    logic              frame_ok_q, frame_ok_d;
    logic              crc_bad, frame_bad;

    crc32_d8 u_crc32_d8 (
        .crc_i   (crc_q),
        .data_i  (rx_if.s_rx_data),
        .crc_c_o (crc_upd)
    );

    assign crc_bad   = (crc_q != CRC32_RESIDUE);
    assign frame_bad = crc_bad | err_q | (cnt_q < CNT_W'(MIN_FRAME));

    // Next-state and output decode. cnt_q counts bytes since SFD, so the
    // 4-byte holdback is full once cnt_q>=4 and the hold stage once cnt_q>=5.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        dl_d       = dl_q;
        hold_d     = hold_q;
        err_d      = err_q;
        beat_d     = '0;
        tvalid_d   = 1'b0;
        crc_err_d  = 1'b0;
        frame_ok_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_if.s_rx_dv) begin
                    state_d = (rx_if.s_rx_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!rx_if.s_rx_dv) begin
                    state_d = IDLE;
                end else if (rx_if.s_rx_data == SFD_BYTE) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                    crc_d   = CRC32_INIT;
                    err_d   = 1'b0;
                end else if (rx_if.s_rx_data != PREAMBLE_BYTE) begin
                    state_d = DROP;
                end
            end
            PAYLOAD: begin
                if (rx_if.s_rx_dv) begin
                    crc_d = crc_upd;
                    cnt_d = cnt_q + CNT_W'(1);
                    dl_d  = {dl_q[2:0], rx_if.s_rx_data};
                    if (rx_if.s_rx_er) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q >= CNT_W'(4)) begin
                        hold_d = dl_q[3];
                    end
                    if (cnt_q == CNT_W'(MAX_FRAME)) begin
                        // Truncate: close the frame as bad and discard the rest.
                        tvalid_d     = 1'b1;
                        beat_d.tdata = hold_q;
                        beat_d.tlast = 1'b1;
                        beat_d.tuser = 1'b1;
                        state_d      = DROP;
                    end else if (cnt_q >= CNT_W'(5)) begin
                        tvalid_d     = 1'b1;
                        beat_d.tdata = hold_q;
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q >= CNT_W'(5)) begin
                        tvalid_d     = 1'b1;
                        beat_d.tdata = hold_q;
                        beat_d.tlast = 1'b1;
                        beat_d.tuser = frame_bad;
                        crc_err_d    = crc_bad;
                        frame_ok_d   = !frame_bad;
                    end
                end
            end
            DROP: begin
                if (!rx_if.s_rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            crc_q      <= CRC32_INIT;
            cnt_q      <= '0;
            dl_q       <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
            beat_q     <= '0;
            tvalid_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            frame_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            dl_q       <= dl_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            beat_q     <= beat_d;
            tvalid_q   <= tvalid_d;
            crc_err_q  <= crc_err_d;
            frame_ok_q <= frame_ok_d;
        end
    end

    assign rx_if.m_rx_axis_tdata  = beat_q.tdata;
    assign rx_if.m_rx_axis_tvalid = tvalid_q;
    assign rx_if.m_rx_axis_tlast  = beat_q.tlast;
    assign rx_if.m_rx_axis_tuser  = beat_q.tuser;
    assign rx_if.o_crc_err        = crc_err_q;
    assign rx_if.o_frame_ok       = frame_ok_q;

endmodule

// File: tb/tb_eth_mac_rx_framer.sv
// Scoreboard bench for eth_mac_rx_framer: directed frames, expected beats queued at stimulus time.
module tb_eth_mac_rx_framer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       crc_err;
        logic       ok;
    } exp_t;

    logic clk_125 = 1'b0;
    logic reset_n = 1'b0;

    eth_mac_rx_framer_if rx_if ();

    eth_mac_rx_framer #(
        .MIN_FRAME (64),
        .MAX_FRAME (1518)
    ) dut (
        .clk_125 (clk_125),
        .reset_n (reset_n),
        .rx_if   (rx_if)
    );

    always #4 clk_125 = ~clk_125;

    int         checks = 0;
    int         fails  = 0;
    exp_t       exp_q[$];
    logic [7:0] tx_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Wire image: 7x55, D5, payload bytes 0,1,2..., optional FCS (optionally bit 0 flipped).
    task automatic make_frame(input int n, input bit with_fcs, input bit bad_fcs);
        logic [31:0] c;
        logic [7:0]  b;
        tx_q.delete();
        repeat (7) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = 8'(i);
            tx_q.push_back(b);
            c = crc_byte(c, b);
        end
        c = ~c;
        if (bad_fcs) c[0] = ~c[0];
        if (with_fcs) for (int k = 0; k < 4; k++) tx_q.push_back(c[8*k +: 8]);
    endtask

    task automatic expect_beats(input int n, input bit user, input bit cerr, input bit ok);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data    = 8'(i);
            e.last    = (i == n - 1);
            e.user    = (i == n - 1) ? user : 1'b0;
            e.crc_err = (i == n - 1) ? cerr : 1'b0;
            e.ok      = (i == n - 1) ? ok   : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Drive tx_q with dv high (er on wire index er_at), then hold dv low for gap cycles.
    task automatic send(input int er_at, input int gap);
        foreach (tx_q[i]) begin
            @(posedge clk_125); #1;
            rx_if.s_rx_data = tx_q[i];
            rx_if.s_rx_dv   = 1'b1;
            rx_if.s_rx_er   = (i == er_at);
        end
        @(posedge clk_125); #1;
        rx_if.s_rx_data = 8'h00;
        rx_if.s_rx_dv   = 1'b0;
        rx_if.s_rx_er   = 1'b0;
        repeat (gap - 1) @(posedge clk_125);
    endtask

    task automatic settle(input string name);
        repeat (8) @(posedge clk_125);
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every valid beat must match the head of the scoreboard; idle cycles carry no sideband.
    always @(negedge clk_125) begin
        exp_t e;
        exp_t got;
        got = {rx_if.m_rx_axis_tdata, rx_if.m_rx_axis_tlast, rx_if.m_rx_axis_tuser,
               rx_if.o_crc_err, rx_if.o_frame_ok};
        if (rx_if.m_rx_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_beat got=%h exp=none at %0t", got, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat{data,last,user,crc_err,ok}", 32'(got), 32'(e));
            end
        end else if (reset_n) begin
            check("idle_sideband", 32'(got[3:0]), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.s_rx_data = 8'h00;
        rx_if.s_rx_dv   = 1'b0;
        rx_if.s_rx_er   = 1'b0;
        repeat (3) @(posedge clk_125);
        #1;
        check("reset_outputs", 32'({rx_if.m_rx_axis_tvalid, rx_if.m_rx_axis_tlast,
              rx_if.m_rx_axis_tuser, rx_if.o_crc_err, rx_if.o_frame_ok, rx_if.m_rx_axis_tdata}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_125);

        // Good minimum-size frame (64 bytes incl. FCS).
        make_frame(60, 1, 0); expect_beats(60, 0, 0, 1); send(-1, 3); settle("good60");

        // FCS bit 0 flipped.
        make_frame(60, 1, 1); expect_beats(60, 1, 1, 0); send(-1, 3); settle("badfcs");

        // Runt with valid FCS.
        make_frame(20, 1, 0); expect_beats(20, 1, 0, 0); send(-1, 3); settle("runt20");

        // Five bytes after SFD: one beat, runt.
        make_frame(1, 1, 0); expect_beats(1, 1, 0, 0); send(-1, 3); settle("runt1");

        // Three bytes after SFD: silently discarded.
        make_frame(3, 0, 0); send(-1, 3); settle("short3");

        // Four bytes after SFD (FCS only): silently discarded.
        make_frame(0, 1, 0); send(-1, 3); settle("short4");

        // PHY error on payload byte 10.
        make_frame(60, 1, 0); expect_beats(60, 1, 0, 0); send(8 + 10, 3); settle("rxer");

        // Bad preamble, then a good frame.
        tx_q.delete();
        tx_q.push_back(8'h55); tx_q.push_back(8'h55); tx_q.push_back(8'h54);
        tx_q.push_back(8'hD5); tx_q.push_back(8'h00); tx_q.push_back(8'h01);
        send(-1, 2); settle("badpre");
        make_frame(60, 1, 0); expect_beats(60, 0, 0, 1); send(-1, 3); settle("after_badpre");

        // Oversize: truncated to MAX_FRAME-4 payload beats, closed as bad, no pulses.
        make_frame(2000, 1, 0); expect_beats(1514, 1, 0, 0); send(-1, 3); settle("oversize");

        // Back-to-back frames with a single dv-low cycle between them.
        make_frame(60, 1, 0); expect_beats(60, 0, 0, 1); send(-1, 1);
        make_frame(61, 1, 0); expect_beats(61, 0, 0, 1); send(-1, 3); settle("b2b");

        // Reset at payload byte 30: beats 0..23 already seen, beat 24 is cleared by reset.
        make_frame(60, 1, 0); expect_beats(24, 0, 0, 0);
        exp_q[23].last = 1'b0;
        foreach (tx_q[i]) begin
            @(posedge clk_125); #1;
            if (i == 8 + 30) begin
                reset_n = 1'b0;
                #1;
                check("reset_midframe", 32'({rx_if.m_rx_axis_tvalid, rx_if.m_rx_axis_tlast,
                      rx_if.m_rx_axis_tuser, rx_if.o_crc_err, rx_if.o_frame_ok}), 32'd0);
            end
            if (i == 8 + 32) reset_n = 1'b1;
            rx_if.s_rx_data = tx_q[i];
            rx_if.s_rx_dv   = 1'b1;
            rx_if.s_rx_er   = 1'b0;
        end
        @(posedge clk_125); #1;
        rx_if.s_rx_dv   = 1'b0;
        rx_if.s_rx_data = 8'h00;
        repeat (2) @(posedge clk_125);
        settle("reset_mid");
        make_frame(60, 1, 0); expect_beats(60, 0, 0, 1); send(-1, 3); settle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
